// File: rtl/dram_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data RAM.
// Define DRAM_ARB_ADDR_CHECK_EN to reject addresses >= DEPTH with an error response.
module dram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              ram_ena,
  output logic              ram_rea,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

`ifdef DRAM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic              rr_ptr;
  logic              pend_valid, pend_id, pend_err;
  logic              gnt0, gnt1, gnt, sel, sel_we, oob;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [31:0]       addr_ext;

  // Grants are suppressed while reset is held so every output drops at once.
  always_comb begin
    gnt0      = !reset && req0_valid && (!req1_valid || !rr_ptr);
    gnt1      = !reset && req1_valid && (!req0_valid ||  rr_ptr);
    gnt       = gnt0 | gnt1;
    sel       = gnt1;
    sel_we    = sel ? req1_we    : req0_we;
    sel_addr  = sel ? req1_addr  : req0_addr;
    sel_wdata = sel ? req1_wdata : req0_wdata;
    addr_ext  = 32'(sel_addr);
    oob       = ADDR_CHECK && (addr_ext >= 32'(DEPTH));
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ram_ena  = gnt && !oob;
    ram_wea  = ram_ena && sel_we;
    ram_rea  = ram_ena && !sel_we;
    ram_addr = ram_ena ? sel_addr : '0;
    ram_din  = ram_wea ? sel_wdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      pend_valid <= 1'b0;
      pend_id    <= 1'b0;
      pend_err   <= 1'b0;
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
    end else begin
      if (gnt) rr_ptr <= !sel;
      pend_valid <= gnt && !sel_we;
      pend_id    <= sel;
      pend_err   <= oob;
      if (gnt0 && gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (gnt1 && gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end

  // Rejected reads never touched the RAM, so their data is forced to zero.
  always_comb begin
    rsp0_valid = pend_valid && !pend_id;
    rsp1_valid = pend_valid &&  pend_id;
    rsp0_err   = rsp0_valid && pend_err;
    rsp1_err   = rsp1_valid && pend_err;
    rsp0_rdata = (rsp0_valid && !pend_err) ? ram_dout : '0;
    rsp1_rdata = (rsp1_valid && !pend_err) ? ram_dout : '0;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized scoreboard bench for dram_arbiter with a RAM model and a reference model.
module tb_dram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef DRAM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int              cyc;
    bit              id;
    bit [DATA_W-1:0] data;
    bit              err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic              v [2];
  logic              we [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wd [2];
  logic rdy0, rdy1, rv0, rv1, re0, re1;
  logic [DATA_W-1:0] rd0, rd1;
  logic ram_ena, ram_rea, ram_wea;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [CNT_W-1:0]  cnt0, cnt1;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_we(we[0]), .req0_addr(addr[0]), .req0_wdata(wd[0]),
    .req0_ready(rdy0), .rsp0_valid(rv0), .rsp0_rdata(rd0), .rsp0_err(re0),
    .req1_valid(v[1]), .req1_we(we[1]), .req1_addr(addr[1]), .req1_wdata(wd[1]),
    .req1_ready(rdy1), .rsp1_valid(rv1), .rsp1_rdata(rd1), .rsp1_err(re1),
    .ram_ena(ram_ena), .ram_rea(ram_rea), .ram_wea(ram_wea), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .gnt_cnt0(cnt0), .gnt_cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM seen by the arbiter.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addr] <= ram_din;
    if (ram_ena && ram_rea) ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: who was served last decides who is preferred next.
  rsp_t q[$];
  bit [DATA_W-1:0] ref_mem [int];
  int  last_served = 1;
  int  mcnt [2] = '{0, 0};
  bit  acc [2] = '{0, 0};
  bit  e0, e1, m_oob;
  int  g;
  rsp_t it;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {rdy0, rdy1, rv0, rv1, re0, re1, ram_ena, ram_rea, ram_wea}, 0);
      chk("reset_cnt", {cnt0, cnt1}, 0);
      q.delete();
      last_served = 1;
      mcnt = '{0, 0};
      acc  = '{0, 0};
    end else begin
      e0 = v[0] && (!v[1] || last_served == 1);
      e1 = v[1] && (!v[0] || last_served == 0);
      chk("req0_ready", rdy0, e0);
      chk("req1_ready", rdy1, e1);
      chk("gnt_cnt0", cnt0, mcnt[0]);
      chk("gnt_cnt1", cnt1, mcnt[1]);
      acc[0] = e0;
      acc[1] = e1;
      if (e0 || e1) begin
        g = e1 ? 1 : 0;
        m_oob = CHK && (int'(addr[g]) >= DEPTH);
        chk("ram_ena", ram_ena, !m_oob);
        if (!m_oob) begin
          chk("ram_wea", ram_wea, we[g]);
          chk("ram_rea", ram_rea, !we[g]);
          chk("ram_addr", ram_addr, addr[g]);
          if (we[g]) chk("ram_din", ram_din, wd[g]);
        end else begin
          chk("ram_strobes_oob", {ram_rea, ram_wea}, 0);
        end
        last_served = g;
        if (mcnt[g] < CMAX) mcnt[g]++;
        if (!we[g]) begin
          it.cyc  = cyc + 1;
          it.id   = g[0];
          it.err  = m_oob;
          it.data = (m_oob || !ref_mem.exists(int'(addr[g]))) ? '0 : ref_mem[int'(addr[g])];
          q.push_back(it);
        end else if (!m_oob) begin
          ref_mem[int'(addr[g])] = wd[g];
        end
      end else begin
        chk("ram_idle", {ram_ena, ram_rea, ram_wea}, 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is offered.
  always @(negedge clk) begin
    if (!reset) begin
      if (!rv0) chk("rsp0_idle", {rd0, re0}, 0);
      if (!rv1) chk("rsp1_idle", {rd1, re1}, 0);
      if (rv0 || rv1) begin
        chk("rsp_onehot", {rv0, rv1}, {1'b0, 1'b1} << rv0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected @cyc %0d: got rsp%0d expected none", cyc, rv1 ? 1 : 0);
        end else begin
          it = q.pop_front();
          chk("rsp_cycle", cyc, it.cyc);
          chk("rsp_id", rv1, it.id);
          chk("rsp_rdata", rv1 ? rd1 : rd0, it.data);
          chk("rsp_err", rv1 ? re1 : re0, it.err);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing @cyc %0d: got none expected rsp%0d", cyc, q[0].id);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit vv, input bit w, input int a, input logic [DATA_W-1:0] d);
    v[r]    = vv;
    we[r]   = w;
    addr[r] = ADDR_W'(a);
    wd[r]   = d;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {rdy0, rdy1, rv0, rv1, ram_ena, ram_rea, ram_wea}, 0);
    chk("async_reset_cnt", {cnt0, cnt1}, 0);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int maxa;
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(2);
    reset = 1'b0;

    // write then read back through requester 0
    set_req(0, 1, 1, 3, 32'hDEADBEEF); tick(1);
    set_req(0, 1, 0, 3, 0);            tick(1);
    set_req(0, 0, 0, 0, 0);            tick(3);

    // contention alternates, RAM survives reset
    set_req(0, 1, 1, 1, 32'h1111_1111); tick(1);
    set_req(0, 1, 1, 2, 32'h2222_2222); tick(1);
    set_req(0, 0, 0, 0, 0);
    do_reset();
    set_req(0, 1, 0, 1, 0);
    set_req(1, 1, 0, 2, 0);
    tick(4);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(2);
    chk("alt_cnt0", cnt0, 2);
    chk("alt_cnt1", cnt1, 2);

    // lone requester 1, then requester 0 wins contention
    do_reset();
    set_req(1, 1, 0, 5, 0); tick(3);
    set_req(0, 1, 0, 6, 0); tick(1);
    chk("contend_cnt0", cnt0, 1);
    chk("contend_cnt1", cnt1, 3);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(2);

    // reset right after a read accept drops the response
    set_req(0, 1, 0, 3, 0); tick(1);
    set_req(1, 1, 0, 2, 0);
    do_reset();
    tick(1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(3);

    // saturation
    do_reset();
    set_req(0, 1, 1, 0, 32'hCAFE_0000);
    tick((1 << CNT_W) + 5);
    set_req(0, 0, 0, 0, 0);
    tick(1);
    chk("sat_cnt0", cnt0, 16'hFFFF);

`ifdef DRAM_ARB_ADDR_CHECK_EN
    set_req(1, 1, 0, 20, 0);            tick(1);
    set_req(1, 0, 0, 0, 0);             tick(2);
    set_req(1, 1, 1, 20, 32'hBAD0BAD0); tick(1);
    set_req(1, 1, 0, 4, 0);             tick(1);
    set_req(1, 0, 0, 0, 0);             tick(2);
`endif

    maxa = CHK ? 2 * DEPTH - 1 : DEPTH - 1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r] || !v[r]) begin
          if ($urandom_range(0, 99) < 70)
            set_req(r, 1, 1'($urandom_range(0, 1)), $urandom_range(0, maxa), $urandom);
          else
            v[r] = 1'b0;
        end
      end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
